// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and memory-stage (DM) requesters.
// Build option ARB_FAIR_EN: IDLE contention goes to the port not served last; default is DM over IF.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;

    logic              grant_vld;
    logic              grant_dm;
    logic              idle_pick_dm;
    logic              done_edge;

`ifdef ARB_FAIR_EN
    assign idle_pick_dm = dm_req & (~if_req | (last_grant_q == OWN_IF));
`else
    assign idle_pick_dm = dm_req;
`endif

    assign done_edge = (state_q == ST_BUSY) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus grant decision; DONE only considers the port that was not just served.
    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_dm  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant_vld = 1'b1;
                    grant_dm  = idle_pick_dm;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (owner_q == OWN_IF && dm_req) begin
                    grant_vld = 1'b1;
                    grant_dm  = 1'b1;
                end else if (owner_q == OWN_DM && if_req) begin
                    grant_vld = 1'b1;
                    grant_dm  = 1'b0;
                end
                state_d = grant_vld ? ST_BUSY : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en_d     = grant_vld;
        mem_we_d     = grant_vld & grant_dm & dm_we;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            mem_addr_d = grant_dm ? dm_addr : if_addr;
            owner_d    = owner_t'(grant_dm);
            cnt_d      = CNT_INIT;
            if (grant_dm) begin
                mem_wdata_d = dm_wdata;
            end
        end else if (state_q == ST_BUSY && cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (done_edge) begin
            last_grant_d = owner_q;
        end
        if_ack_d   = done_edge && (owner_q == OWN_IF);
        dm_ack_d   = done_edge && (owner_q == OWN_DM);
        if_rdata_d = if_ack_d ? mem_rdata : if_rdata_q;
        // dm_we is still held by the requester at completion, so it tells load from store.
        dm_rdata_d = (dm_ack_d && !dm_we) ? mem_rdata : dm_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign stall_f   = if_req & ~if_ack_q;
    assign stall_m   = dm_req & ~dm_ack_q;

endmodule
